// File: rtl/quad_esc_pkg.sv
// Shared constants and channel naming for the quad ESC pulse driver.
package quad_esc_pkg;

  localparam int SPD_W          = 11;
  localparam int N_CHAN         = 4;

  localparam int PERIOD_DEF     = 125000;
  localparam int MIN_PULSE_DEF  = 50000;
  localparam int SCALE_DEF      = 24;
  localparam int WDOG_FRMS_DEF  = 25;

  typedef enum logic [1:0] {
    FRNT = 2'd0,
    BCK  = 2'd1,
    LFT  = 2'd2,
    RGHT = 2'd3
  } chan_e;

endpackage

// File: rtl/esc_chan.sv
// One ESC channel: pending/active pulse width pair and a registered PWM compare.
module esc_chan
  import quad_esc_pkg::*;
#(
  parameter int CW        = 17,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int SCALE     = SCALE_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt,
  input  logic [SPD_W-1:0] spd,
  input  logic             bndry,
  input  logic             fs,
  input  logic [CW-1:0]    cnt,
  output logic             pwm
);

  localparam logic [CW-1:0] MIN_W = CW'(MIN_PULSE);

  logic [CW-1:0] nxt_w_q, nxt_w_d;
  logic [CW-1:0] act_w_q, act_w_d;
  logic          pwm_q, pwm_d;
  logic [CW-1:0] spd_w;

  assign spd_w = CW'(32'(MIN_PULSE) + 32'(spd) * 32'(SCALE));

  // act_w samples the pre-write nxt_w at the boundary, so a write landing on
  // the last frame cycle only shows up one frame later.
  always_comb begin
    nxt_w_d = nxt_w_q;
    if (wrt) begin
      nxt_w_d = spd_w;
    end else if (fs) begin
      nxt_w_d = MIN_W;
    end

    act_w_d = act_w_q;
    if (bndry) begin
      act_w_d = fs ? MIN_W : nxt_w_q;
    end

    pwm_d = (cnt < act_w_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_w_q <= MIN_W;
      act_w_q <= MIN_W;
      pwm_q   <= 1'b0;
    end else begin
      nxt_w_q <= nxt_w_d;
      act_w_q <= act_w_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/esc_pwm_drv.sv
// Four-channel ESC pulse generator: frame counter, command watchdog, frame start strobe.
module esc_pwm_drv
  import quad_esc_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEF,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int SCALE     = SCALE_DEF,
  parameter int WDOG_FRMS = WDOG_FRMS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wrt,
  input  logic [SPD_W-1:0] frnt_spd,
  input  logic [SPD_W-1:0] bck_spd,
  input  logic [SPD_W-1:0] lft_spd,
  input  logic [SPD_W-1:0] rght_spd,
  output logic             frnt_pwm,
  output logic             bck_pwm,
  output logic             lft_pwm,
  output logic             rght_pwm,
  output logic             frm_strt,
  output logic             stale
);

  localparam int CW  = $clog2(PERIOD);
  localparam int WDW = $clog2(WDOG_FRMS + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(PERIOD - 1);
  localparam logic [WDW-1:0] WD_MAX   = WDW'(WDOG_FRMS);

  if (MIN_PULSE + ((1 << SPD_W) - 1) * SCALE >= PERIOD) begin : g_bad_cfg
    $error("esc_pwm_drv: full-scale pulse does not fit inside PERIOD");
  end

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           stale_q, stale_d;
  logic           frm_strt_q, frm_strt_d;
  logic           bndry;

  assign bndry = (cnt_q == CNT_LAST);

  // wrt is a single-cycle strobe with no back-pressure: speeds are valid only
  // in the cycle wrt is high and are always accepted.
  always_comb begin
    cnt_d      = bndry ? '0 : cnt_q + 1'b1;
    frm_strt_d = (cnt_q == '0);
    wd_d       = wd_q;
    stale_d    = stale_q;
    if (wrt) begin
      wd_d    = '0;
      stale_d = 1'b0;
    end else if (bndry && (wd_q != WD_MAX)) begin
      wd_d = wd_q + 1'b1;
      if ((wd_q + 1'b1) == WD_MAX) begin
        stale_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      wd_q       <= '0;
      stale_q    <= 1'b0;
      frm_strt_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      stale_q    <= stale_d;
      frm_strt_q <= frm_strt_d;
    end
  end

  logic [SPD_W-1:0] spd [N_CHAN];
  logic [N_CHAN-1:0] pwm;

  assign spd[FRNT] = frnt_spd;
  assign spd[BCK]  = bck_spd;
  assign spd[LFT]  = lft_spd;
  assign spd[RGHT] = rght_spd;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    esc_chan #(
      .CW        (CW),
      .MIN_PULSE (MIN_PULSE),
      .SCALE     (SCALE)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .wrt   (wrt),
      .spd   (spd[i]),
      .bndry (bndry),
      .fs    (stale_q),
      .cnt   (cnt_q),
      .pwm   (pwm[i])
    );
  end

  assign frnt_pwm = pwm[FRNT];
  assign bck_pwm  = pwm[BCK];
  assign lft_pwm  = pwm[LFT];
  assign rght_pwm = pwm[RGHT];
  assign frm_strt = frm_strt_q;
  assign stale    = stale_q;

endmodule

// File: tb/tb_esc_pwm_drv.sv
// Scoreboard bench for esc_pwm_drv using a shortened frame so the run stays small.
module tb_esc_pwm_drv;

  localparam int TP = 2600;
  localparam int TM = 400;
  localparam int TS = 1;
  localparam int TW = 4;
  localparam int W  = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wrt = 1'b0;
  logic [10:0] frnt_spd = '0;
  logic [10:0] bck_spd = '0;
  logic [10:0] lft_spd = '0;
  logic [10:0] rght_spd = '0;
  logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm;
  logic        frm_strt, stale;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  esc_pwm_drv #(
    .PERIOD    (TP),
    .MIN_PULSE (TM),
    .SCALE     (TS),
    .WDOG_FRMS (TW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt      (wrt),
    .frnt_spd (frnt_spd),
    .bck_spd  (bck_spd),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .frnt_pwm (frnt_pwm),
    .bck_pwm  (bck_pwm),
    .lft_pwm  (lft_pwm),
    .rght_pwm (rght_pwm),
    .frm_strt (frm_strt),
    .stale    (stale)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pk(input int f, input int b, input int l, input int r);
    return {12'(f), 12'(b), 12'(l), 12'(r)};
  endfunction

  function automatic int pwm_vec();
    return int'({frnt_pwm, bck_pwm, lft_pwm, rght_pwm});
  endfunction

  // monitor: measures each completed frame and checks it against the queue head
  initial begin : monitor
    int hi[4];
    int len;
    int frm;
    bit in_frame;
    logic [W-1:0] e;
    logic [3:0] p;
    in_frame = 1'b0;
    len = 0;
    frm = 0;
    foreach (hi[c]) hi[c] = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 1'b0;
        continue;
      end
      p = {frnt_pwm, bck_pwm, lft_pwm, rght_pwm};
      if (frm_strt) begin
        if (in_frame) begin
          frm++;
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_frame_%0d", frm), 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("frame_len_%0d", frm), len, TP);
            for (int c = 0; c < 4; c++) begin
              chk($sformatf("width_f%0d_ch%0d", frm, c), hi[c], int'(e[47-12*c -: 12]));
            end
          end
        end
        in_frame = 1'b1;
        len = 0;
        foreach (hi[c]) hi[c] = 0;
      end
      if (in_frame) begin
        len++;
        for (int c = 0; c < 4; c++) hi[c] += int'(p[3-c]);
      end
    end
  end

  // driver tasks
  task automatic next_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frm_strt && n < 2 * TP);
    if (!frm_strt) chk("frm_strt_timeout", 0, 1);
  endtask

  task automatic enter(input int f, input int b, input int l, input int r);
    int n;
    next_frame(n);
    exp_q.push_back(pk(f, b, l, r));
  endtask

  task automatic wr_pulse(input int f, input int b, input int l, input int r);
    frnt_spd = 11'(f);
    bck_spd  = 11'(b);
    lft_spd  = 11'(l);
    rght_spd = 11'(r);
    wrt = 1'b1;
    @(negedge clk);
    wrt = 1'b0;
  endtask

  // called right after a frame start (cnt=1); the write is sampled at cnt=k
  task automatic wr_at(input int k, input int f, input int b, input int l, input int r);
    repeat (k - 1) @(negedge clk);
    wr_pulse(f, b, l, r);
  endtask

  initial begin : driver
    int n;
    int t;
    repeat (3) @(negedge clk);
    chk("rst_pwm", pwm_vec(), 0);
    chk("rst_frm_strt", int'(frm_strt), 0);
    chk("rst_stale", int'(stale), 0);
    rst_n = 1'b1;

    // no commands: minimum pulse, watchdog trips after TW frames
    for (int f = 1; f <= 4; f++) begin
      enter(TM, TM, TM, TM);
      chk($sformatf("stale_idle_f%0d", f), int'(stale), 0);
    end
    enter(TM, TM, TM, TM);
    chk("stale_set_idle", int'(stale), 1);
    wr_at(10, 0, 1, 1000, 2047);
    chk("stale_clr_wrt", int'(stale), 0);

    // write on the last frame cycle takes effect one frame late
    enter(TM, TM + 1, TM + 1000, TM + 2047);
    wr_at(TP - 1, 500, 1, 1000, 2047);
    enter(TM, TM + 1, TM + 1000, TM + 2047);
    enter(TM + 500, TM + 1, TM + 1000, TM + 2047);

    // two writes in one frame: last one wins
    wr_at(50, 100, 1, 1000, 2047);
    repeat (500) @(negedge clk);
    wr_pulse(200, 300, 0, 2047);
    enter(TM + 200, TM + 300, TM, TM + 2047);

    // steady writes keep the watchdog quiet
    wr_at(100, 300, 300, 300, 300);
    for (int f = 10; f <= 14; f++) begin
      enter(TM + 300, TM + 300, TM + 300, TM + 300);
      chk($sformatf("stale_busy_f%0d", f), int'(stale), 0);
      wr_at(100, 300, 300, 300, 300);
    end
    enter(TM + 300, TM + 300, TM + 300, TM + 300);
    chk("stale_f15", int'(stale), 0);
    enter(TM + 300, TM + 300, TM + 300, TM + 300);
    enter(TM + 300, TM + 300, TM + 300, TM + 300);
    chk("stale_f17", int'(stale), 0);
    enter(TM + 300, TM + 300, TM + 300, TM + 300);
    chk("stale_f18", int'(stale), 1);
    enter(TM, TM, TM, TM);
    chk("stale_f19", int'(stale), 1);
    wr_at(10, 0, 1, 1000, 2047);
    chk("stale_clr_f19", int'(stale), 0);
    enter(TM, TM + 1, TM + 1000, TM + 2047);

    // asynchronous reset in the middle of a pulse
    next_frame(n);
    repeat (1199) @(negedge clk);
    chk("pre_rst_pwm", pwm_vec(), 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_vec(), 0);
    chk("async_rst_stale", int'(stale), 0);
    chk("async_rst_frm_strt", int'(frm_strt), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    next_frame(n);
    chk("restart_latency", n, 1);
    exp_q.push_back(pk(TM, TM, TM, TM));
    enter(TM, TM, TM, TM);

    t = 0;
    while (exp_q.size() > 0 && t < 3 * TP) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() > 0) chk("drain_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
